// File: rtl/ed25519_fetch_pkg.sv
// Shared types and constants for the Ed25519 operand fetcher.
package ed25519_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  localparam int unsigned WORDS_PER_OP = 8;
  localparam int unsigned SLOT_ONE     = 1;
  localparam int unsigned SLOT_D       = 14;
  localparam int unsigned SLOT_D_LEN   = 15;
  localparam int unsigned SLOT_L       = 16;

  function automatic logic [8:0] slot_base(input logic [5:0] slot);
    return {slot, 3'b000};
  endfunction

endpackage

// File: rtl/ed25519_operand_fetch.sv
// Read-side sequencer: fetches one 8-word operand from ed25519_operand_bank, re-issuing reads lost to writes.
// Optional retry counter enabled by macro ED25519_FETCH_STALLCNT_EN.
module ed25519_operand_fetch
  import ed25519_fetch_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned WORDS  = 8,
  parameter int unsigned SLOT_W = 6
) (
  input  logic                      iClk,
  input  logic                      iRst_n,
  input  logic                      iReq,
  input  logic [SLOT_W-1:0]         iSlot,
  output logic                      oReq_rdy,
  output logic [ADDR_W-1:0]         oB_addr,
  input  logic [DATA_W-1:0]         iB,
  input  logic                      iBank_wr,
  output logic [DATA_W*WORDS-1:0]   oOp,
  output logic                      oOp_vld,
  input  logic                      iOp_rdy,
  output logic [15:0]               oStall_cnt
);

  localparam int unsigned PTR_W = $clog2(WORDS);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(WORDS - 1);

  fetch_state_e                   state_q, state_d;
  logic [SLOT_W-1:0]              slot_q, slot_d;
  logic [PTR_W-1:0]               issue_ptr_q, issue_ptr_d;
  logic                           issue_done_q, issue_done_d;
  logic [PTR_W-1:0]               cap_ptr_q, cap_ptr_d;
  logic                           rd_ok_q, rd_ok_d;
  logic [WORDS-1:0][DATA_W-1:0]   words_q, words_d;

  // Once all words are issued the address parks on the last word of the slot.
  assign oB_addr  = slot_base(slot_q) + ADDR_W'(issue_done_q ? LAST : issue_ptr_q);
  assign oReq_rdy = (state_q == IDLE);
  assign oOp_vld  = (state_q == HOLD);
  assign oOp      = words_q;

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    issue_ptr_d  = issue_ptr_q;
    issue_done_d = issue_done_q;
    cap_ptr_d    = cap_ptr_q;
    rd_ok_d      = 1'b0;
    words_d      = words_q;
    case (state_q)
      IDLE: begin
        if (iReq) begin
          slot_d       = iSlot;
          issue_ptr_d  = '0;
          issue_done_d = 1'b0;
          cap_ptr_d    = '0;
          state_d      = FETCH;
        end
      end
      FETCH: begin
        if (!issue_done_q && !iBank_wr) begin
          rd_ok_d = 1'b1;
          if (issue_ptr_q == LAST) begin
            issue_ptr_d  = '0;
            issue_done_d = 1'b1;
          end else begin
            issue_ptr_d = issue_ptr_q + PTR_W'(1);
          end
        end
        // A read overridden by a write never sets rd_ok, so capture order follows issue order.
        if (rd_ok_q) begin
          words_d[cap_ptr_q] = iB;
          cap_ptr_d          = cap_ptr_q + PTR_W'(1);
          if (cap_ptr_q == LAST) state_d = HOLD;
        end
      end
      HOLD: begin
        if (iOp_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q      <= IDLE;
      slot_q       <= '0;
      issue_ptr_q  <= '0;
      issue_done_q <= 1'b0;
      cap_ptr_q    <= '0;
      rd_ok_q      <= 1'b0;
      words_q      <= '0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      issue_ptr_q  <= issue_ptr_d;
      issue_done_q <= issue_done_d;
      cap_ptr_q    <= cap_ptr_d;
      rd_ok_q      <= rd_ok_d;
      words_q      <= words_d;
    end
  end

`ifdef ED25519_FETCH_STALLCNT_EN
  logic [15:0] stall_q;
  logic        stall_inc;

  assign stall_inc  = (state_q == FETCH) && !issue_done_q && iBank_wr;
  assign oStall_cnt = stall_q;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n)                         stall_q <= '0;
    else if (stall_inc && stall_q != '1) stall_q <= stall_q + 16'd1;
  end
`else
  assign oStall_cnt = '0;
`endif

endmodule

// File: tb/tb_ed25519_operand_fetch.sv
// Directed bench for ed25519_operand_fetch with a behavioural operand bank (constant slots + RAM, write-priority address).
module tb_ed25519_operand_fetch;
  import ed25519_fetch_pkg::*;

  localparam logic [255:0] K_BX  = 256'h216936d3cd6e53fec0a4e231fdd6dc5c692cc7609525a7b2c9562d608f25d51a;
  localparam logic [255:0] K_BY  = 256'h6666666666666666666666666666666666666666666666666666666666666658;
  localparam logic [255:0] K_T   = 256'h67875f0fd78b766566ea4e8e64abe37d20f09f80775152f56dde8ab3a5b7dda3;
  localparam logic [255:0] K_ONE = 256'h1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req;
  logic [5:0]   slot;
  logic         req_rdy;
  logic [8:0]   b_addr;
  logic [31:0]  b_rd;
  logic         a_wr;
  logic [8:0]   a_addr;
  logic [31:0]  a_d;
  logic [255:0] op;
  logic         op_vld;
  logic         op_rdy;
  logic [15:0]  stall_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  ed25519_operand_fetch #(.DATA_W(32), .ADDR_W(9), .WORDS(8), .SLOT_W(6)) dut (
    .iClk(clk), .iRst_n(rst_n), .iReq(req), .iSlot(slot), .oReq_rdy(req_rdy),
    .oB_addr(b_addr), .iB(b_rd), .iBank_wr(a_wr), .oOp(op), .oOp_vld(op_vld),
    .iOp_rdy(op_rdy), .oStall_cnt(stall_cnt)
  );

  // Bank model: registered address, port A write takes the shared address.
  logic [31:0] mem [0:511];
  logic [8:0]  bank_addr_q;

  always @(posedge clk) begin
    if (a_wr) mem[a_addr] <= a_d;
    bank_addr_q <= a_wr ? a_addr : b_addr;
  end

  always_comb begin
    case (bank_addr_q[8:3])
      6'd0:  b_rd = '0;
      6'd1:  b_rd = K_ONE[{bank_addr_q[2:0], 5'b0} +: 32];
      6'd14: b_rd = K_BX[{bank_addr_q[2:0], 5'b0} +: 32];
      6'd15: b_rd = K_BY[{bank_addr_q[2:0], 5'b0} +: 32];
      6'd16: b_rd = K_T[{bank_addr_q[2:0], 5'b0} +: 32];
      default: b_rd = mem[bank_addr_q];
    endcase
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue a request and wait for oOp_vld; lat counts edges after the accepting edge.
  task automatic do_fetch(input logic [5:0] s, output int unsigned lat);
    @(posedge clk); #1;
    req = 1'b1; slot = s;
    @(posedge clk); #1;
    req = 1'b0; lat = 0;
    while (!op_vld && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_op(input string tag);
    op_rdy = 1'b1;
    @(posedge clk); #1;
    op_rdy = 1'b0;
    check({tag, "_vld_low"}, 256'(op_vld), 256'd0);
    check({tag, "_rdy_high"}, 256'(req_rdy), 256'd1);
  endtask

  int unsigned  lat;
  int unsigned  e;
  logic [255:0] exp20;
  logic [255:0] held;
  logic [255:0] by_v;
  logic [15:0]  exp_stall;

  initial begin
    rst_n = 1'b0; req = 1'b0; slot = '0; a_wr = 1'b0; a_addr = '0; a_d = '0; op_rdy = 1'b0;
    #2;
    check("rst_req_rdy", 256'(req_rdy), 256'd1);
    check("rst_b_addr", 256'(b_addr), 256'd0);
    check("rst_op", op, 256'd0);
    check("rst_op_vld", 256'(op_vld), 256'd0);
    check("rst_stall", 256'(stall_cnt), 256'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    do_fetch(6'(SLOT_D), lat);
    check("slot14_lat", 256'(lat), 256'd9);
    check("slot14_op", op, K_BX);
    release_op("slot14");

    do_fetch(6'(SLOT_ONE), lat);
    check("slot1_op", op, K_ONE);
    release_op("slot1");

    do_fetch(6'(SLOT_D_LEN), lat);
    check("slot15_op", op, K_BY);
    release_op("slot15");

    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      a_wr = 1'b1; a_addr = 9'(160 + i); a_d = 32'h1000 + 32'(i);
      exp20[i*32 +: 32] = 32'h1000 + 32'(i);
    end
    @(posedge clk); #1;
    a_wr = 1'b0;
    do_fetch(6'd20, lat);
    check("slot20_lat", 256'(lat), 256'd9);
    check("slot20_op", op, exp20);
    release_op("slot20");
    check("stall_after_idle_writes", 256'(stall_cnt), 256'd0);

    // Writes on the 3rd and 6th FETCH cycles, aimed at an unrelated RAM slot.
    @(posedge clk); #1;
    req = 1'b1; slot = 6'(SLOT_L);
    @(posedge clk); #1;
    req = 1'b0; e = 0;
    @(posedge clk); #1; e = 1;
    @(posedge clk); #1; e = 2; a_wr = 1'b1; a_addr = 9'd240; a_d = 32'hdead0001;
    @(posedge clk); #1; e = 3; a_wr = 1'b0;
    @(posedge clk); #1; e = 4;
    @(posedge clk); #1; e = 5; a_wr = 1'b1; a_addr = 9'd241; a_d = 32'hdead0002;
    @(posedge clk); #1; e = 6; a_wr = 1'b0;
    while (!op_vld && e < 200) begin
      @(posedge clk); #1;
      e++;
    end
    check("slot16_stall_lat", 256'(e), 256'd11);
    check("slot16_op", op, K_T);
`ifdef ED25519_FETCH_STALLCNT_EN
    exp_stall = 16'd2;
`else
    exp_stall = 16'd0;
`endif
    check("slot16_stall_cnt", 256'(stall_cnt), 256'(exp_stall));

    held = op;
    req = 1'b1; slot = 6'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_vld", 256'(op_vld), 256'd1);
      check("hold_op", op, K_T);
      check("hold_req_rdy", 256'(req_rdy), 256'd0);
    end
    req = 1'b0;
    release_op("hold");
    @(posedge clk); #1;
    check("hold_no_queued_fetch", 256'(op_vld), 256'd0);
    check("hold_op_unchanged", op, held);

    // Reset after four words of slot 15 have been captured.
    @(posedge clk); #1;
    req = 1'b1; slot = 6'(SLOT_D_LEN);
    @(posedge clk); #1;
    req = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    by_v = K_BY;
    check("partial_low_words", 256'(op[127:0]), 256'(by_v[127:0]));
    rst_n = 1'b0;
    #1;
    check("midrst_op", op, 256'd0);
    check("midrst_vld", 256'(op_vld), 256'd0);
    check("midrst_req_rdy", 256'(req_rdy), 256'd1);
    check("midrst_stall", 256'(stall_cnt), 256'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_fetch(6'(SLOT_D), lat);
    check("post_rst_lat", 256'(lat), 256'd9);
    check("post_rst_op", op, K_BX);
    release_op("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
